// File: rtl/pc_unit_if.sv
// Bus bundle between the decode/branch logic (master) and the PC unit (slave).
interface pc_unit_if #(
    parameter int WIDTH = 32
);
    logic             ena;
    logic [2:0]       sel;
    logic [WIDTH-1:0] offset;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_uflow;
    logic             ras_oflow;
    logic             misalign;

    modport master (
        output ena, sel, offset, target,
        input  pc, pc_plus, ras_empty, ras_full, ras_uflow, ras_oflow, misalign
    );

    modport slave (
        input  ena, sel, offset, target,
        output pc, pc_plus, ras_empty, ras_full, ras_uflow, ras_oflow, misalign
    );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC selection plus a circular return-address stack.
// Optional misaligned-target trap is enabled by defining PC_MISALIGN_TRAP_EN.
module pc_unit #(
    parameter int          WIDTH     = 32,
    parameter logic [31:0] RESET_VEC = 32'h0040_0000,
    parameter logic [31:0] EXC_VEC   = 32'h0040_0004,
    parameter int          INC       = 4,
    parameter int          RAS_DEPTH = 4
) (
    input logic       clk,
    input logic       rst,
    pc_unit_if.slave  bus
);

    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);

    localparam logic [WIDTH-1:0] RST_PC  = WIDTH'(RESET_VEC);
    localparam logic [WIDTH-1:0] EXC_PC  = WIDTH'(EXC_VEC);
    localparam logic [WIDTH-1:0] INC_W   = WIDTH'(INC);
    localparam logic [PW-1:0]    PTR_MAX = PW'(RAS_DEPTH - 1);
    localparam logic [CW-1:0]    CNT_MAX = CW'(RAS_DEPTH);

    localparam logic [2:0] SEL_BRANCH = 3'b001;
    localparam logic [2:0] SEL_JUMP   = 3'b010;
    localparam logic [2:0] SEL_CALL   = 3'b011;
    localparam logic [2:0] SEL_RET    = 3'b100;
    localparam logic [2:0] SEL_EXC    = 3'b101;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_MAX) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
        return (p == '0) ? PTR_MAX : p - PW'(1);
    endfunction

    logic [WIDTH-1:0]        pc_p1;
    logic [WIDTH-1:0]        pc_p0;
    logic [WIDTH-1:0]        pc_plus;
    logic signed [WIDTH-1:0] offset_s;
    logic [WIDTH-1:0]        cand;
    logic [WIDTH-1:0]        stack [RAS_DEPTH];
    logic [PW-1:0]           ptr;
    logic [CW-1:0]           count;
    logic                    full;
    logic                    push;
    logic                    pop;
    logic                    uflow_p0;
    logic                    oflow_p0;
    logic                    uflow_p1;
    logic                    oflow_p1;

    assign offset_s = bus.offset;
    assign pc_plus  = pc_p1 + INC_W;
    assign full     = (count == CNT_MAX);

`ifdef PC_MISALIGN_TRAP_EN
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INC - 1);

    function automatic logic misaligned(input logic [WIDTH-1:0] addr);
        return (addr & ALIGN_MASK) != '0;
    endfunction

    logic chk;
    logic misalign_p0;
    logic misalign_p1;

    assign chk = bus.sel inside {SEL_BRANCH, SEL_JUMP, SEL_CALL, SEL_RET};
`endif

    // Stage p0: next-PC selection and stack control
    always_comb begin
        pc_p0    = pc_p1;
        cand     = pc_plus;
        push     = 1'b0;
        pop      = 1'b0;
        uflow_p0 = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        misalign_p0 = 1'b0;
`endif
        if (bus.ena) begin
            unique case (bus.sel)
                SEL_BRANCH: cand = pc_plus + WIDTH'(offset_s);
                SEL_JUMP:   cand = bus.target;
                SEL_CALL: begin
                    cand = bus.target;
                    push = 1'b1;
                end
                SEL_RET: begin
                    if (count != '0) begin
                        cand = stack[ptr_dec(ptr)];
                        pop  = 1'b1;
                    end else begin
                        cand     = bus.target;
                        uflow_p0 = 1'b1;
                    end
                end
                SEL_EXC:    cand = EXC_PC;
                default:    cand = pc_plus;
            endcase
            pc_p0 = cand;
`ifdef PC_MISALIGN_TRAP_EN
            // A trapped return has already consumed its entry; only the push is cancelled.
            if (chk && misaligned(cand)) begin
                pc_p0       = EXC_PC;
                push        = 1'b0;
                misalign_p0 = 1'b1;
            end
`endif
        end
        oflow_p0 = push && full;
    end

    // Stage p1: architectural state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_p1    <= RST_PC;
            ptr      <= '0;
            count    <= '0;
            uflow_p1 <= 1'b0;
            oflow_p1 <= 1'b0;
        end else begin
            pc_p1    <= pc_p0;
            uflow_p1 <= uflow_p0;
            oflow_p1 <= oflow_p0;
            if (push) begin
                ptr <= ptr_inc(ptr);
                if (!full) count <= count + CW'(1);
            end else if (pop) begin
                ptr   <= ptr_dec(ptr);
                count <= count - CW'(1);
            end
        end
    end

    // Stack storage carries no reset; entries are meaningless until pushed.
    always_ff @(posedge clk) begin
        if (push) stack[ptr] <= pc_plus;
    end

`ifdef PC_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) misalign_p1 <= 1'b0;
        else     misalign_p1 <= misalign_p0;
    end
    assign bus.misalign = misalign_p1;
`else
    assign bus.misalign = 1'b0;
`endif

    assign bus.pc        = pc_p1;
    assign bus.pc_plus   = pc_plus;
    assign bus.ras_empty = (count == '0);
    assign bus.ras_full  = full;
    assign bus.ras_uflow = uflow_p1;
    assign bus.ras_oflow = oflow_p1;

endmodule
